// File: rtl/aes_key_sched_ctrl.sv
// Sequential AES key-schedule controller: expands one word per clock through a shared SubWord
// unit and serves 128-bit round keys by index. Optional feature macro: KEYSCHED_ZEROIZE_EN.
module aes_key_sched_ctrl #(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic              clk,
    input  logic              reset,
`ifdef KEYSCHED_ZEROIZE_EN
    input  logic              zeroize,
`endif
    input  logic [NK*32-1:0]  key_in,
    input  logic              key_valid,
    output logic              key_ready,
    output logic              busy,
    output logic              keys_valid,
    input  logic [3:0]        rk_idx,
    output logic [127:0]      rk_out,
    output logic              rk_valid
);

    localparam int NW = 4 * (NR + 1);
    localparam int IW = $clog2(NW + 1);
    localparam int AW = $clog2(NW);
    localparam int PW = $clog2(NK);

    generate
        if (NR != NK + 6) begin : g_bad_cfg
            $error("aes_key_sched_ctrl: NR must equal NK+6");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            else      p = p;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the AES affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    state_t          state_r;
    logic [IW-1:0]   i_r;
    logic [PW-1:0]   phase_r;
    logic [7:0]      rcon_r;
    logic            key_ready_r;
    logic            busy_r;
    logic            keys_valid_r;
    logic [127:0]    rk_out_r;
    logic            rk_valid_r;
    logic [31:0]     w_r [NW];

    logic            zero_s;
    logic            hs_s;
    logic [31:0]     prev_s;
    logic [31:0]     back_s;
    logic [31:0]     sw_in_s;
    logic [31:0]     sw_out_s;
    logic [31:0]     t_s;
    logic [31:0]     new_word_s;
    logic [AW-1:0]   rd_base_s;
    logic [127:0]    rd_key_s;

`ifdef KEYSCHED_ZEROIZE_EN
    assign zero_s = zeroize;
`else
    assign zero_s = 1'b0;
`endif

    assign key_ready  = key_ready_r;
    assign busy       = busy_r;
    assign keys_valid = keys_valid_r;
    assign rk_out     = rk_out_r;
    assign rk_valid   = rk_valid_r;

    // Next schedule word; phase_r tracks i%NK so no divider is needed for NK=6
    always_comb begin
        hs_s     = key_valid & key_ready_r;
        prev_s   = w_r[AW'(i_r - IW'(1))];
        back_s   = w_r[AW'(i_r - IW'(NK))];
        if (phase_r == PW'(0)) sw_in_s = rot_word(prev_s);
        else                   sw_in_s = prev_s;
        sw_out_s = sub_word(sw_in_s);
        if (phase_r == PW'(0))                  t_s = sw_out_s ^ {rcon_r, 24'h000000};
        else if (NK > 6 && phase_r == PW'(4))   t_s = sw_out_s;
        else                                    t_s = prev_s;
        new_word_s = back_s ^ t_s;
    end

    // Round-key gather for the read port
    always_comb begin
        rd_base_s = AW'({rk_idx, 2'b00});
        if (rk_idx <= 4'(NR)) begin
            rd_key_s = {w_r[rd_base_s], w_r[rd_base_s + AW'(1)],
                        w_r[rd_base_s + AW'(2)], w_r[rd_base_s + AW'(3)]};
        end else begin
            rd_key_s = 128'h0;
        end
    end

    // Word storage: deliberately not cleared by reset, only by zeroize or a new key
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (zero_s) begin
                for (int k = 0; k < NW; k++) w_r[k] <= 32'h0;
            end else if (hs_s) begin
                for (int k = 0; k < NK; k++) w_r[k] <= key_in[(NK-1-k)*32 +: 32];
            end else if (busy_r) begin
                w_r[AW'(i_r)] <= new_word_s;
            end
        end
    end

    // Control FSM with registered status outputs
    always_ff @(posedge clk) begin
        if (reset || zero_s) begin
            state_r      <= IDLE;
            i_r          <= IW'(0);
            phase_r      <= PW'(0);
            rcon_r       <= 8'h01;
            key_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            keys_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (hs_s) begin
                        state_r      <= EXPAND;
                        i_r          <= IW'(NK);
                        phase_r      <= PW'(0);
                        rcon_r       <= 8'h01;
                        key_ready_r  <= 1'b0;
                        busy_r       <= 1'b1;
                        keys_valid_r <= 1'b0;
                    end
                end
                EXPAND: begin
                    i_r     <= i_r + IW'(1);
                    phase_r <= (phase_r == PW'(NK - 1)) ? PW'(0) : phase_r + PW'(1);
                    if (phase_r == PW'(0)) rcon_r <= xtime(rcon_r);
                    if (i_r == IW'(NW - 1)) begin
                        state_r      <= DONE;
                        key_ready_r  <= 1'b1;
                        busy_r       <= 1'b0;
                        keys_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    i_r          <= IW'(0);
                    phase_r      <= PW'(0);
                    rcon_r       <= 8'h01;
                    key_ready_r  <= 1'b1;
                    busy_r       <= 1'b0;
                    keys_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Registered read port; old schedule still readable in the cycle a new key is taken
    always_ff @(posedge clk) begin
        if (reset || zero_s) begin
            rk_out_r   <= 128'h0;
            rk_valid_r <= 1'b0;
        end else if (rk_idx <= 4'(NR)) begin
            rk_out_r   <= rd_key_s;
            rk_valid_r <= keys_valid_r;
        end else begin
            rk_out_r   <= 128'h0;
            rk_valid_r <= 1'b0;
        end
    end

endmodule
